// File: rtl/mips_pkg.sv
// Shared MIPS datapath constants, ALU control codes and issue-stage control bundle.
// The ALU_ISSUE_FWD_EN macro selects forwarding muxes over a hazard interlock in the issue stage.
package mips_pkg;

    localparam int DATA_W = 32;
    localparam int REG_AW = 5;
    localparam int CTRL_W = 4;

    localparam logic [CTRL_W-1:0] ALU_AND = 4'b0000;
    localparam logic [CTRL_W-1:0] ALU_OR  = 4'b0001;
    localparam logic [CTRL_W-1:0] ALU_ADD = 4'b0010;
    localparam logic [CTRL_W-1:0] ALU_XOR = 4'b0011;
    localparam logic [CTRL_W-1:0] ALU_SUB = 4'b0110;
    localparam logic [CTRL_W-1:0] ALU_SLT = 4'b0111;
    localparam logic [CTRL_W-1:0] ALU_SLL = 4'b1000;
    localparam logic [CTRL_W-1:0] ALU_SRL = 4'b1001;
    localparam logic [CTRL_W-1:0] ALU_NOR = 4'b1100;

    typedef struct packed {
        logic [CTRL_W-1:0] alu_ctrl;
        logic              use_imm;
        logic              is_shift;
        logic              reg_write;
        logic [REG_AW-1:0] rd;
    } issue_ctrl_t;

endpackage

// File: rtl/fwd_mux.sv
// Operand forwarding select for one source register: EX/MEM beats MEM/WB beats stored data.
// Instantiated only when ALU_ISSUE_FWD_EN is defined.
module fwd_mux
    import mips_pkg::*;
(
    input  logic [REG_AW-1:0] src_addr,
    input  logic [DATA_W-1:0] stored_data,
    input  logic              exm_reg_write,
    input  logic [REG_AW-1:0] exm_rd_addr,
    input  logic [DATA_W-1:0] exm_result,
    input  logic              mwb_reg_write,
    input  logic [REG_AW-1:0] mwb_rd_addr,
    input  logic [DATA_W-1:0] mwb_result,
    output logic [DATA_W-1:0] fwd_data
);

    logic src_nonzero;
    assign src_nonzero = (src_addr != '0);

    // r0 is hardwired to zero, so a producer targeting it must never be forwarded
    always_comb begin
        fwd_data = stored_data;
        if (src_nonzero && exm_reg_write && (exm_rd_addr == src_addr)) begin
            fwd_data = exm_result;
        end else if (src_nonzero && mwb_reg_write && (mwb_rd_addr == src_addr)) begin
            fwd_data = mwb_result;
        end
    end

endmodule

// File: rtl/alu_issue_stage.sv
// ID/EX issue stage: one-entry valid/ready pipeline register feeding ALU operands and control.
// ALU_ISSUE_FWD_EN defined: EX/MEM and MEM/WB forwarding; undefined: hazard interlock with operand refresh.
module alu_issue_stage
    import mips_pkg::*;
#(
    parameter int DATA_W = mips_pkg::DATA_W,
    parameter int REG_AW = mips_pkg::REG_AW,
    parameter int CTRL_W = mips_pkg::CTRL_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_rs_data,
    input  logic [DATA_W-1:0] in_rt_data,
    input  logic [REG_AW-1:0] in_rs_addr,
    input  logic [REG_AW-1:0] in_rt_addr,
    input  logic [REG_AW-1:0] in_rd_addr,
    input  logic [DATA_W-1:0] in_imm,
    input  logic [4:0]        in_shamt,
    input  logic              in_use_imm,
    input  logic              in_is_shift,
    input  logic [CTRL_W-1:0] in_alu_ctrl,
    input  logic              in_reg_write,
    input  logic              flush,
    input  logic              exm_reg_write,
    input  logic [REG_AW-1:0] exm_rd_addr,
    input  logic [DATA_W-1:0] exm_result,
    input  logic              mwb_reg_write,
    input  logic [REG_AW-1:0] mwb_rd_addr,
    input  logic [DATA_W-1:0] mwb_result,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [CTRL_W-1:0] alu_ctrl,
    output logic [REG_AW-1:0] out_rd_addr,
    output logic              out_reg_write
);

    logic              valid;
    issue_ctrl_t       ctrl_q;
    logic [REG_AW-1:0] rs_q;
    logic [REG_AW-1:0] rt_q;
    logic [DATA_W-1:0] rs_data_q;
    logic [DATA_W-1:0] rt_data_q;
    logic [DATA_W-1:0] imm_q;
    logic [4:0]        shamt_q;

    logic [DATA_W-1:0] fwd_rs;
    logic [DATA_W-1:0] fwd_rt;
    logic              hazard;
    logic              load;
    logic              xfer;

`ifdef ALU_ISSUE_FWD_EN
    fwd_mux u_fwd_rs (
        .src_addr      (rs_q),
        .stored_data   (rs_data_q),
        .exm_reg_write (exm_reg_write),
        .exm_rd_addr   (exm_rd_addr),
        .exm_result    (exm_result),
        .mwb_reg_write (mwb_reg_write),
        .mwb_rd_addr   (mwb_rd_addr),
        .mwb_result    (mwb_result),
        .fwd_data      (fwd_rs)
    );

    fwd_mux u_fwd_rt (
        .src_addr      (rt_q),
        .stored_data   (rt_data_q),
        .exm_reg_write (exm_reg_write),
        .exm_rd_addr   (exm_rd_addr),
        .exm_result    (exm_result),
        .mwb_reg_write (mwb_reg_write),
        .mwb_rd_addr   (mwb_rd_addr),
        .mwb_result    (mwb_result),
        .fwd_data      (fwd_rt)
    );

    assign hazard = 1'b0;
`else
    logic rs_hit;
    logic rt_hit;
    logic unused_results;

    assign fwd_rs = rs_data_q;
    assign fwd_rt = rt_data_q;

    // Only operands actually consumed by the ALU can stall the entry
    assign rs_hit = (rs_q != '0) && !ctrl_q.is_shift &&
                    ((exm_reg_write && (exm_rd_addr == rs_q)) ||
                     (mwb_reg_write && (mwb_rd_addr == rs_q)));
    assign rt_hit = (rt_q != '0) && !ctrl_q.use_imm &&
                    ((exm_reg_write && (exm_rd_addr == rt_q)) ||
                     (mwb_reg_write && (mwb_rd_addr == rt_q)));
    assign hazard = valid && (rs_hit || rt_hit);

    assign unused_results = ^{exm_result, mwb_result};
`endif

    assign out_valid = valid && !hazard;
    assign in_ready  = !valid || (out_valid && out_ready);
    assign load      = in_valid && in_ready;
    assign xfer      = out_valid && out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            valid     <= 1'b0;
            ctrl_q    <= '0;
            rs_q      <= '0;
            rt_q      <= '0;
            rs_data_q <= '0;
            rt_data_q <= '0;
            imm_q     <= '0;
            shamt_q   <= '0;
        end else if (flush) begin
            valid <= 1'b0;
        end else if (load) begin
            valid            <= 1'b1;
            ctrl_q.alu_ctrl  <= in_alu_ctrl;
            ctrl_q.use_imm   <= in_use_imm;
            ctrl_q.is_shift  <= in_is_shift;
            ctrl_q.reg_write <= in_reg_write;
            ctrl_q.rd        <= in_rd_addr;
            rs_q             <= in_rs_addr;
            rt_q             <= in_rt_addr;
            rs_data_q        <= in_rs_data;
            rt_data_q        <= in_rt_data;
            imm_q            <= in_imm;
            shamt_q          <= in_shamt;
        end else if (xfer) begin
            valid <= 1'b0;
        end else if (hazard) begin
            // Decode re-presents the stalled instruction; the write-before-read file shows fresh values
            rs_data_q <= in_rs_data;
            rt_data_q <= in_rt_data;
        end
    end

    assign alu_a         = ctrl_q.is_shift ? {{(DATA_W-5){1'b0}}, shamt_q} : fwd_rs;
    assign alu_b         = ctrl_q.use_imm ? imm_q : fwd_rt;
    assign alu_ctrl      = ctrl_q.alu_ctrl;
    assign out_rd_addr   = ctrl_q.rd;
    assign out_reg_write = valid && ctrl_q.reg_write;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Self-checking bench for alu_issue_stage: directed scenarios, then random traffic against a reference model.
// Follows ALU_ISSUE_FWD_EN to choose between forwarding and interlock expectations.
module tb_alu_issue_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_rs_data;
    logic [31:0] in_rt_data;
    logic [4:0]  in_rs_addr;
    logic [4:0]  in_rt_addr;
    logic [4:0]  in_rd_addr;
    logic [31:0] in_imm;
    logic [4:0]  in_shamt;
    logic        in_use_imm;
    logic        in_is_shift;
    logic [3:0]  in_alu_ctrl;
    logic        in_reg_write;
    logic        flush;
    logic        exm_reg_write;
    logic [4:0]  exm_rd_addr;
    logic [31:0] exm_result;
    logic        mwb_reg_write;
    logic [4:0]  mwb_rd_addr;
    logic [31:0] mwb_result;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [3:0]  alu_ctrl;
    logic [4:0]  out_rd_addr;
    logic        out_reg_write;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    alu_issue_stage dut (
        .clk           (clk),
        .rst           (rst),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_rs_data    (in_rs_data),
        .in_rt_data    (in_rt_data),
        .in_rs_addr    (in_rs_addr),
        .in_rt_addr    (in_rt_addr),
        .in_rd_addr    (in_rd_addr),
        .in_imm        (in_imm),
        .in_shamt      (in_shamt),
        .in_use_imm    (in_use_imm),
        .in_is_shift   (in_is_shift),
        .in_alu_ctrl   (in_alu_ctrl),
        .in_reg_write  (in_reg_write),
        .flush         (flush),
        .exm_reg_write (exm_reg_write),
        .exm_rd_addr   (exm_rd_addr),
        .exm_result    (exm_result),
        .mwb_reg_write (mwb_reg_write),
        .mwb_rd_addr   (mwb_rd_addr),
        .mwb_result    (mwb_result),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .alu_a         (alu_a),
        .alu_b         (alu_b),
        .alu_ctrl      (alu_ctrl),
        .out_rd_addr   (out_rd_addr),
        .out_reg_write (out_reg_write)
    );

    // Reference model: the instruction the stage should currently be holding
    bit          known = 0;
    bit          m_valid;
    logic [4:0]  m_rs, m_rt, m_rd, m_sh;
    logic [31:0] m_rsd, m_rtd, m_imm;
    logic [3:0]  m_ctrl;
    bit          m_ui, m_is, m_rw;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Producers in priority order: the youngest in-flight result wins
    function automatic logic [31:0] ref_operand(input logic [4:0] a, input logic [31:0] stored);
        logic        wr  [2];
        logic [4:0]  dst [2];
        logic [31:0] val [2];
        wr[0] = exm_reg_write; dst[0] = exm_rd_addr; val[0] = exm_result;
        wr[1] = mwb_reg_write; dst[1] = mwb_rd_addr; val[1] = mwb_result;
`ifdef ALU_ISSUE_FWD_EN
        if (a != 0) begin
            for (int p = 0; p < 2; p++) begin
                if (wr[p] && dst[p] == a) return val[p];
            end
        end
`endif
        return stored;
    endfunction

    function automatic bit pending_write(input logic [4:0] a);
        return (a != 0) && ((exm_reg_write && exm_rd_addr == a) || (mwb_reg_write && mwb_rd_addr == a));
    endfunction

    function automatic bit ref_stalled();
`ifdef ALU_ISSUE_FWD_EN
        return 1'b0;
`else
        return m_valid && ((!m_is && pending_write(m_rs)) || (!m_ui && pending_write(m_rt)));
`endif
    endfunction

    task automatic check_model();
        bit ev, er;
        if (!known) return;
        ev = m_valid && !ref_stalled();
        er = !m_valid || (ev && out_ready);
        chk("out_valid", out_valid, ev);
        chk("in_ready", in_ready, er);
        chk("out_reg_write", out_reg_write, m_valid && m_rw);
        if (m_valid) begin
            chk("alu_a", alu_a, m_is ? {27'd0, m_sh} : ref_operand(m_rs, m_rsd));
            chk("alu_b", alu_b, m_ui ? m_imm : ref_operand(m_rt, m_rtd));
            chk("alu_ctrl", alu_ctrl, m_ctrl);
            chk("out_rd_addr", out_rd_addr, m_rd);
        end
    endtask

    task automatic update_model();
        bit ev, er, stalled;
        stalled = ref_stalled();
        ev = m_valid && !stalled;
        er = !m_valid || (ev && out_ready);
        if (rst) begin
            known = 1; m_valid = 0;
            m_rs = 0; m_rt = 0; m_rd = 0; m_sh = 0;
            m_rsd = 0; m_rtd = 0; m_imm = 0; m_ctrl = 0;
            m_ui = 0; m_is = 0; m_rw = 0;
        end else if (!known) begin
            return;
        end else if (flush) begin
            m_valid = 0;
        end else if (in_valid && er) begin
            m_valid = 1;
            m_rs = in_rs_addr; m_rt = in_rt_addr; m_rd = in_rd_addr; m_sh = in_shamt;
            m_rsd = in_rs_data; m_rtd = in_rt_data; m_imm = in_imm; m_ctrl = in_alu_ctrl;
            m_ui = in_use_imm; m_is = in_is_shift; m_rw = in_reg_write;
        end else if (ev && out_ready) begin
            m_valid = 0;
        end else if (stalled) begin
            m_rsd = in_rs_data; m_rtd = in_rt_data;
        end
    endtask

    task automatic tick();
        @(negedge clk);
        check_model();
        @(posedge clk);
        update_model();
        #1;
    endtask

    task automatic offer(input logic [3:0] c, input logic [4:0] rs, input logic [4:0] rt,
                         input logic [4:0] rd, input logic [31:0] rsd, input logic [31:0] rtd,
                         input logic [31:0] imm, input logic [4:0] sh, input bit ui, input bit is);
        in_valid = 1; in_alu_ctrl = c; in_rs_addr = rs; in_rt_addr = rt; in_rd_addr = rd;
        in_rs_data = rsd; in_rt_data = rtd; in_imm = imm; in_shamt = sh;
        in_use_imm = ui; in_is_shift = is; in_reg_write = 1;
    endtask

    task automatic quiet_buses();
        exm_reg_write = 0; exm_rd_addr = 0; exm_result = 0;
        mwb_reg_write = 0; mwb_rd_addr = 0; mwb_result = 0;
    endtask

    initial begin
        rst = 1; flush = 0; out_ready = 1;
        quiet_buses();
        offer(4'b0010, 5'd1, 5'd2, 5'd3, 32'h1234, 32'h5678, 32'h9, 5'd0, 0, 0);

        // Reset held two cycles with an instruction offered
        tick();
        tick();
        rst = 0; in_valid = 0;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_alu_a", alu_a, 0);
        chk("rst_alu_b", alu_b, 0);
        chk("rst_alu_ctrl", alu_ctrl, 0);
        chk("rst_reg_write", out_reg_write, 0);
        chk("rst_in_ready", in_ready, 1);

        // Basic ADD issue
        offer(4'b0010, 5'd3, 5'd4, 5'd2, 32'h5, 32'h7, 32'h0, 5'd0, 0, 0);
        tick();
        chk("basic_alu_a", alu_a, 32'h5);
        chk("basic_alu_b", alu_b, 32'h7);
        chk("basic_alu_ctrl", alu_ctrl, 4'b0010);
        chk("basic_out_valid", out_valid, 1);

        // Back-to-back issue, one per cycle
        for (int i = 0; i < 4; i++) begin
            offer(4'b0110, 5'(i + 1), 5'(i + 10), 5'(i + 20), 32'h100 + i, 32'h200 + i, 32'h0, 5'd0, 0, 0);
            chk("b2b_in_ready", in_ready, 1);
            tick();
            chk("b2b_alu_a", alu_a, 32'h100 + i);
            chk("b2b_out_valid", out_valid, 1);
        end
        in_valid = 0;
        tick();

`ifdef ALU_ISSUE_FWD_EN
        // Forwarding priority on a held rs=8
        out_ready = 0;
        offer(4'b0010, 5'd8, 5'd9, 5'd1, 32'h11, 32'h22, 32'h0, 5'd0, 0, 0);
        tick();
        in_valid = 0;
        exm_reg_write = 1; exm_rd_addr = 8; exm_result = 32'hAA;
        mwb_reg_write = 1; mwb_rd_addr = 8; mwb_result = 32'hBB;
        #1;
        chk("fwd_exm_wins", alu_a, 32'hAA);
        exm_reg_write = 0;
        #1;
        chk("fwd_mwb", alu_a, 32'hBB);
        out_ready = 1;
        quiet_buses();
        offer(4'b0010, 5'd0, 5'd9, 5'd1, 32'h33, 32'h22, 32'h0, 5'd0, 0, 0);
        tick();
        in_valid = 0; out_ready = 0;
        exm_reg_write = 1; exm_rd_addr = 0; exm_result = 32'hAA;
        mwb_reg_write = 1; mwb_rd_addr = 0; mwb_result = 32'hBB;
        #1;
        chk("fwd_r0_stored", alu_a, 32'h33);
        quiet_buses();
        out_ready = 1;
        tick();
`else
        // Interlock: held rs=5 while EX/MEM targets r5 for two cycles
        out_ready = 1;
        offer(4'b0010, 5'd5, 5'd0, 5'd1, 32'h50, 32'h0, 32'h0, 5'd0, 0, 0);
        tick();
        in_valid = 0; in_rs_data = 32'h55;
        exm_reg_write = 1; exm_rd_addr = 5; exm_result = 32'hEE;
        #1;
        chk("lock_valid_c1", out_valid, 0);
        chk("lock_in_ready", in_ready, 0);
        tick();
        chk("lock_valid_c2", out_valid, 0);
        tick();
        exm_reg_write = 0;
        #1;
        chk("lock_release", out_valid, 1);
        chk("lock_refresh", alu_a, 32'h55);
        tick();
        chk("lock_drained", out_valid, 0);
`endif

        // Shift and immediate operand selection
        out_ready = 1;
        quiet_buses();
        offer(4'b1000, 5'd9, 5'd1, 5'd3, 32'hDEAD, 32'h1, 32'h0, 5'd4, 0, 1);
        tick();
        chk("sll_alu_a", alu_a, 32'h4);
        chk("sll_alu_b", alu_b, 32'h1);
        chk("sll_ctrl", alu_ctrl, 4'b1000);
        offer(4'b0010, 5'd2, 5'd7, 5'd7, 32'h10, 32'h99, 32'hFFFF_FFFC, 5'd0, 1, 0);
        tick();
        chk("addi_alu_b", alu_b, 32'hFFFF_FFFC);
        chk("addi_alu_a", alu_a, 32'h10);
        in_valid = 0;
        tick();

        // Backpressure then flush with a competing load
        out_ready = 0;
        offer(4'b0001, 5'd6, 5'd7, 5'd4, 32'h66, 32'h77, 32'h0, 5'd0, 0, 0);
        tick();
        offer(4'b0011, 5'd1, 5'd2, 5'd5, 32'h1, 32'h2, 32'h0, 5'd0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            chk("bp_in_ready", in_ready, 0);
            tick();
            chk("bp_alu_a", alu_a, 32'h66);
            chk("bp_alu_b", alu_b, 32'h77);
            chk("bp_ctrl", alu_ctrl, 4'b0001);
            chk("bp_out_valid", out_valid, 1);
        end
        flush = 1; out_ready = 1;
        tick();
        flush = 0; in_valid = 0;
        chk("flush_out_valid", out_valid, 0);
        chk("flush_reg_write", out_reg_write, 0);
        tick();
        chk("flush_nothing_loaded", out_valid, 0);

        // Random traffic against the model
        for (int c = 0; c < 600; c++) begin
            rst           = ($urandom_range(0, 99) == 0);
            flush         = ($urandom_range(0, 19) == 0);
            in_valid      = ($urandom_range(0, 2) != 0);
            out_ready     = ($urandom_range(0, 3) != 0);
            in_rs_addr    = 5'($urandom_range(0, 7));
            in_rt_addr    = 5'($urandom_range(0, 7));
            in_rd_addr    = 5'($urandom_range(0, 31));
            in_rs_data    = $urandom;
            in_rt_data    = $urandom;
            in_imm        = $urandom;
            in_shamt      = 5'($urandom_range(0, 31));
            in_use_imm    = 1'($urandom_range(0, 1));
            in_is_shift   = ($urandom_range(0, 3) == 0);
            in_alu_ctrl   = 4'($urandom_range(0, 15));
            in_reg_write  = 1'($urandom_range(0, 1));
            exm_reg_write = 1'($urandom_range(0, 1));
            exm_rd_addr   = 5'($urandom_range(0, 7));
            exm_result    = $urandom;
            mwb_reg_write = 1'($urandom_range(0, 1));
            mwb_rd_addr   = 5'($urandom_range(0, 7));
            mwb_result    = $urandom;
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_issue_stage.md
Name: alu_issue_stage

Overview:
- ID/EX issue stage directly upstream of the 32-bit ALU.
- Holds one decoded instruction in a pipeline register and applies operand forwarding from the EX/MEM and MEM/WB result buses.
- Presents operands and control to the ALU:
  - `alu_a` is rs, or the shift amount for SLL/SRL.
  - `alu_b` is rt or the sign-extended immediate.
  - `alu_ctrl` is the 4-bit ALU code.
- Valid/ready handshake both sides, plus stall and flush support.

Parameters:
- DATA_W, 32, operand/result width.
- REG_AW, 5, register address width.
- CTRL_W, 4, ALU control width; codes match ALU: ADD 0010, SUB 0110, AND 0000, OR 0001, XOR 0011, NOR 1100, SLT 0111, SLL 1000, SRL 1001.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, synchronous, active-high.
- in_valid  in  1  decoded instruction offered.
- in_ready  out  1  stage can accept.
- in_rs_data  in  DATA_W  register-file rs value.
- in_rt_data  in  DATA_W  register-file rt value.
- in_rs_addr  in  REG_AW  rs index.
- in_rt_addr  in  REG_AW  rt index.
- in_rd_addr  in  REG_AW  destination index.
- in_imm  in  DATA_W  sign-extended immediate.
- in_shamt  in  5  shift amount.
- in_use_imm  in  1  select immediate for B.
- in_is_shift  in  1  select shamt for A.
- in_alu_ctrl  in  CTRL_W  ALU operation.
- in_reg_write  in  1  instruction writes rd.
- flush  in  1  kill held and incoming instruction.
- exm_reg_write  in  1  EX/MEM write-enable.
- exm_rd_addr  in  REG_AW  EX/MEM destination.
- exm_result  in  DATA_W  EX/MEM value.
- mwb_reg_write  in  1  MEM/WB write-enable.
- mwb_rd_addr  in  REG_AW  MEM/WB destination.
- mwb_result  in  DATA_W  MEM/WB value.
- out_valid  out  1  operands valid to ALU.
- out_ready  in  1  downstream accepts.
- alu_a  out  DATA_W  ALU operand a.
- alu_b  out  DATA_W  ALU operand b.
- alu_ctrl  out  CTRL_W  ALU control.
- out_rd_addr  out  REG_AW  forwarded destination.
- out_reg_write  out  1  forwarded write-enable.

Behaviour:
- **Storage.** One-entry register: valid bit plus all `in_*` fields. No combinational path from `in_*` to the outputs; latency is 1 cycle.
- **Reset.** `rst`=1 at a clock edge clears valid and zeroes every stored field. After reset:
  - `out_valid`=0, `alu_a`=0, `alu_b`=0, `alu_ctrl`=0000, `out_rd_addr`=0, `out_reg_write`=0.
  - Reset mid-transfer drops the held instruction.
- **Handshake.**
  - `in_ready` = !valid | (out_valid & out_ready).
  - Load occurs when `in_valid & in_ready`.
  - Transfer out occurs when `out_valid & out_ready`.
  - Simultaneous transfer-out and load gives back-to-back issue, 1 instruction per cycle.
- **Hold.** While `out_valid & !out_ready`, all stored fields are frozen and `in_ready`=0.
- **Flush.** `flush`=1 at an edge clears valid and ignores any same-cycle load; `flush` has priority over load. `rst` has priority over `flush`.
- **Forwarding.** Combinational on the held rs/rt each cycle. For each source S:
  - If `exm_reg_write` & `exm_rd_addr`==S & S!=0: use `exm_result`.
  - Else if `mwb_reg_write` & `mwb_rd_addr`==S & S!=0: use `mwb_result`.
  - Else: use the stored value.
  - EX/MEM has priority over MEM/WB. Register 0 is never forwarded.
- **Operand select.**
  - `alu_a` = is_shift ? {27'b0, shamt} : fwd_rs.
  - `alu_b` = use_imm ? imm : fwd_rt.
  - rt is still forwarded for shifts.
- **Invalid entry.** When not valid, `out_reg_write` is forced to 0. The other outputs show stored or zero values, which are don't-care.

Optional Feature:
- Macro ALU_ISSUE_FWD_EN.
- **Defined:** forwarding as above.
- **Undefined:** forwarding muxes are removed and operands come from stored data only. Hazard interlock instead:
  - A hazard exists when a held non-zero rs (if !is_shift) or rt (if !use_imm) matches an asserted exm or mwb destination.
  - During a hazard, `out_valid` is forced 0 and the entry is held.
  - `out_valid` rises on the first cycle the hazard clears.
  - The register file is write-before-read, so the refreshed values are captured from `in_rs_data`/`in_rt_data` re-presented by decode. Decode must keep `in_valid` low while stalled.

Decomposition:
- Shared package `mips_pkg`:
  - ALU control code constants (ADD … NOR).
  - DATA_W and REG_AW constants.
  - Typedef `issue_ctrl_t`: alu_ctrl, use_imm, is_shift, reg_write, rd.
- Sub-module `fwd_mux` (one instance per source operand): selects among the exm, mwb and stored values.

Test Plan:
- **Reset:** `rst`=1 for 2 cycles with `in_valid`=1 → `out_valid`=0, `alu_a`=`alu_b`=0, `in_ready`=1 after reset.
- **Basic issue:** ADD rs=3 (0x5), rt=4 (0x7), `out_ready`=1 → next cycle `alu_a`=5, `alu_b`=7, `alu_ctrl`=0010. Then 4 back-to-back instructions → one transfer per cycle.
- **Forward priority:** held rs=8 with exm rd=8 (0xAA) and mwb rd=8 (0xBB) → `alu_a`=0xAA. With exm cleared → 0xBB. With rs=0 and both matching → stored value.
- **Shift and immediate:** SLL shamt=4, rt=0x1 → `alu_a`=4, `alu_b`=1, ctrl 1000. ADDI imm=0xFFFFFFFC → `alu_b`=0xFFFFFFFC.
- **Backpressure and flush:** `out_ready`=0 for 3 cycles → outputs stable, `in_ready`=0. Then `flush`=1 together with `in_valid`=1 → `out_valid`=0 next cycle, nothing loaded.
- **Interlock (ALU_ISSUE_FWD_EN undefined):** held rs=5 with exm rd=5 asserted 2 cycles → `out_valid`=0 for those cycles, rises the cycle after exm clears.
